// File: rtl/apb_rr_master_if.sv
// Requester-side handshake and APB bus signals for apb_rr_master.
// The master modport is the arbiter's view; the slave modport is the view of
// everything around it (requesters plus the APB slave).
interface apb_rr_master_if;
  // Requester side, two requesters packed side by side (requester i on slice i)
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_accept;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  // APB side
  logic        psel;
  logic        pen;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pready, pslverr, prdata,
    output req_accept, rsp_valid, rsp_rdata, rsp_err, psel, pen, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pready, pslverr, prdata,
    input  req_accept, rsp_valid, rsp_rdata, rsp_err, psel, pen, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_master.sv
// Two-requester round-robin APB master: one transfer in flight, with a
// PREADY wait timer that aborts stuck transfers and reports them as errors.
module apb_rr_master #(
  parameter int unsigned TIMEOUT = 16  // legal range 1..255
) (
  input  logic               CLK,
  input  logic               RST_N,
  apb_rr_master_if.master    io_bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  // Timer value in the ACCESS cycle that completes the TIMEOUT-th wait
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      r_state;
  state_e      w_state_d;

  logic        r_last;      // requester granted most recently
  logic        r_owner;     // requester currently in service
  logic        r_pwrite;
  logic [7:0]  r_paddr;
  logic [7:0]  r_pwdata;
  logic [7:0]  r_wait;
  logic [1:0]  r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_winner;
  logic        w_grant;
  logic        w_done;
  logic        w_abort;
  logic        w_psel;
  logic        w_pen;
  logic [1:0]  w_accept;
  logic [7:0]  w_sel_addr;
  logic [7:0]  w_sel_wdata;

  // Arbitration: a lone requester wins; on contention the one not served last wins
  always_comb begin
    w_winner = 1'b0;
    unique case (io_bus.req_valid)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last;
      default: w_winner = 1'b0;
    endcase
  end

  // Winner's request fields, selected from the packed requester buses
  always_comb begin
    w_sel_addr  = io_bus.req_addr[{w_winner, 3'b000} +: 8];
    w_sel_wdata = io_bus.req_wdata[{w_winner, 3'b000} +: 8];
  end

  // Next-state logic and APB control decode
  always_comb begin
    w_state_d = r_state;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    w_psel    = 1'b0;
    w_pen     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|io_bus.req_valid) begin
          w_grant   = 1'b1;
          w_state_d = StSetup;
        end
      end
      StSetup: begin
        w_psel    = 1'b1;
        w_state_d = StAccess;
      end
      StAccess: begin
        w_psel = 1'b1;
        w_pen  = 1'b1;
        if (io_bus.pready) begin
          w_done    = 1'b1;
          w_state_d = StIdle;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_abort   = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Accept pulse is combinational with the grant but suppressed while in reset
  always_comb begin
    w_accept = 2'b00;
    if (w_grant && RST_N) begin
      w_accept = w_winner ? 2'b10 : 2'b01;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Latch the winning request and remember who was served
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_last   <= 1'b1;  // so requester 0 wins the first contention
      r_owner  <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= 8'h00;
      r_pwdata <= 8'h00;
    end else if (w_grant) begin
      r_last   <= w_winner;
      r_owner  <= w_winner;
      r_pwrite <= io_bus.req_write[w_winner];
      r_paddr  <= w_sel_addr;
      r_pwdata <= w_sel_wdata;
    end
  end

  // Wait timer: cleared when a transfer enters SETUP, counts ACCESS cycles without PREADY
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wait <= 8'h00;
    end else if (w_grant) begin
      r_wait <= 8'h00;
    end else if ((r_state == StAccess) && !io_bus.pready) begin
      r_wait <= r_wait + 8'h01;
    end
  end

  // Response: one-cycle valid pulse after completion/abort; data and error hold afterwards
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      if (w_done || w_abort) begin
        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
        r_rsp_rdata <= (w_done && !r_pwrite) ? io_bus.prdata : 8'h00;
        r_rsp_err   <= w_abort ? 1'b1 : io_bus.pslverr;
      end
    end
  end

  assign io_bus.req_accept = w_accept;
  assign io_bus.rsp_valid  = r_rsp_valid;
  assign io_bus.rsp_rdata  = r_rsp_rdata;
  assign io_bus.rsp_err    = r_rsp_err;
  assign io_bus.psel       = w_psel;
  assign io_bus.pen        = w_pen;
  assign io_bus.pwrite     = r_pwrite;
  assign io_bus.paddr      = r_paddr;
  assign io_bus.pwdata     = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a small registered-PREADY APB slave.
module tb_apb_rr_master;

  logic CLK;
  logic RST_N;
  int   n_cmp;
  int   n_bad;

  // Slave controls
  logic s_ready_en;
  logic s_err;

  // Slave memory; unwritten locations read as {addr[3:0], ~addr[3:0]}
  logic [7:0] mem     [256] = '{default: 8'h00};
  logic       written [256] = '{default: 1'b0};

  apb_rr_master_if u_if ();

  apb_rr_master #(.TIMEOUT(4)) u_dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .io_bus (u_if.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // APB slave: raises PREADY one cycle after it sees PEN (when enabled)
  always @(posedge CLK) begin
    if (!RST_N) begin
      u_if.pready <= 1'b0;
    end else if (u_if.psel && u_if.pen && !u_if.pready && s_ready_en) begin
      u_if.pready <= 1'b1;
    end else begin
      u_if.pready <= 1'b0;
    end
    if (u_if.psel && u_if.pen && u_if.pready && u_if.pwrite) begin
      mem[u_if.paddr]     <= u_if.pwdata;
      written[u_if.paddr] <= 1'b1;
    end
  end

  assign u_if.prdata  = written[u_if.paddr] ? mem[u_if.paddr]
                                            : {u_if.paddr[3:0], ~u_if.paddr[3:0]};
  assign u_if.pslverr = s_err & u_if.pready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic req(input logic [1:0] v, input logic [1:0] w, input logic [15:0] a,
                     input logic [15:0] d);
    u_if.req_valid = v;
    u_if.req_write = w;
    u_if.req_addr  = a;
    u_if.req_wdata = d;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    RST_N      = 1'b0;
    s_ready_en = 1'b1;
    s_err      = 1'b0;
    req(2'b00, 2'b00, 16'h0000, 16'h0000);

    // Reset: accept suppressed, all outputs zero
    step(); u_if.req_valid = 2'b11; #1;
    chk("rst_accept", u_if.req_accept, 2'b00);
    step(); #1;
    chk("rst_psel", u_if.psel, 1'b0);
    chk("rst_pen", u_if.pen, 1'b0);
    chk("rst_pwrite", u_if.pwrite, 1'b0);
    chk("rst_paddr", u_if.paddr, 8'h00);
    chk("rst_pwdata", u_if.pwdata, 8'h00);
    chk("rst_rsp_valid", u_if.rsp_valid, 2'b00);
    chk("rst_rsp_rdata", u_if.rsp_rdata, 8'h00);
    chk("rst_rsp_err", u_if.rsp_err, 1'b0);
    step(); RST_N = 1'b1; u_if.req_valid = 2'b00; #1;
    chk("idle_accept", u_if.req_accept, 2'b00);

    // Req0 writes 0xA5 to 0x03; latency T, T+1 setup, T+2/T+3 access, T+4 response
    step(); req(2'b01, 2'b01, 16'h0003, 16'h00A5); #1;
    chk("t1_accept", u_if.req_accept, 2'b01);
    step(); u_if.req_valid = 2'b00; #1;
    chk("t1_setup_psel", u_if.psel, 1'b1);
    chk("t1_setup_pen", u_if.pen, 1'b0);
    chk("t1_pwrite", u_if.pwrite, 1'b1);
    chk("t1_paddr", u_if.paddr, 8'h03);
    chk("t1_pwdata", u_if.pwdata, 8'hA5);
    step(); #1;
    chk("t1_access1_pen", u_if.pen, 1'b1);
    step(); #1;
    chk("t1_access2_pen", u_if.pen, 1'b1);
    chk("t1_access2_paddr", u_if.paddr, 8'h03);
    chk("t1_no_rsp_yet", u_if.rsp_valid, 2'b00);
    step(); #1;
    chk("t1_idle_psel", u_if.psel, 1'b0);
    chk("t1_rsp_valid", u_if.rsp_valid, 2'b01);
    chk("t1_rsp_err", u_if.rsp_err, 1'b0);
    chk("t1_rsp_rdata", u_if.rsp_rdata, 8'h00);
    step(); #1;
    chk("t1_rsp_pulse_end", u_if.rsp_valid, 2'b00);

    // Req1 reads 0x03 back
    step(); req(2'b10, 2'b00, 16'h0300, 16'h0000); #1;
    chk("t2_accept", u_if.req_accept, 2'b10);
    step(); u_if.req_valid = 2'b00; #1;
    chk("t2_pwrite", u_if.pwrite, 1'b0);
    chk("t2_paddr", u_if.paddr, 8'h03);
    step(); step(); step(); #1;
    chk("t2_rsp_valid", u_if.rsp_valid, 2'b10);
    chk("t2_rsp_rdata", u_if.rsp_rdata, 8'hA5);
    chk("t2_rsp_err", u_if.rsp_err, 1'b0);
    step(); #1;
    chk("t2_rdata_hold", u_if.rsp_rdata, 8'hA5);
    chk("t2_valid_clear", u_if.rsp_valid, 2'b00);

    // Both requesters held: grants alternate 0,1,0,1, response shares the grant cycle
    for (int k = 0; k < 4; k++) begin
      step(); req(2'b11, 2'b00, 16'h0303, 16'h0000); #1;
      chk("rr_accept", u_if.req_accept, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k > 0) chk("rr_rsp_valid", u_if.rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
      step();
      if (k == 3) u_if.req_valid = 2'b00;
      #1;
      chk("rr_setup_psel", u_if.psel, 1'b1);
      chk("rr_setup_pen", u_if.pen, 1'b0);
      step(); step();
    end
    step(); #1;
    chk("rr_last_rsp", u_if.rsp_valid, 2'b10);
    chk("rr_last_rdata", u_if.rsp_rdata, 8'hA5);
    chk("rr_no_accept", u_if.req_accept, 2'b00);

    // PREADY stuck low with TIMEOUT=4: four ACCESS cycles then abort
    s_ready_en = 1'b0;
    step(); req(2'b01, 2'b00, 16'h0005, 16'h0000); #1;
    chk("to_accept", u_if.req_accept, 2'b01);
    step(); u_if.req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("to_access_pen", u_if.pen, 1'b1);
    end
    step(); #1;
    chk("to_psel_low", u_if.psel, 1'b0);
    chk("to_rsp_valid", u_if.rsp_valid, 2'b01);
    chk("to_rsp_err", u_if.rsp_err, 1'b1);
    chk("to_rsp_rdata", u_if.rsp_rdata, 8'h00);
    s_ready_en = 1'b1;

    // Slave error on a read: error flagged and PRDATA still returned
    s_err = 1'b1;
    step(); req(2'b10, 2'b00, 16'h0500, 16'h0000); #1;
    chk("se_accept", u_if.req_accept, 2'b10);
    step(); u_if.req_valid = 2'b00;
    step(); step(); step(); #1;
    chk("se_rsp_valid", u_if.rsp_valid, 2'b10);
    chk("se_rsp_err", u_if.rsp_err, 1'b1);
    chk("se_rsp_rdata", u_if.rsp_rdata, 8'h5A);
    s_err = 1'b0;

    // Reset mid-ACCESS after a req0 grant: silent abort, LAST restored to 1
    step(); req(2'b01, 2'b00, 16'h0003, 16'h0000); #1;
    chk("mr_accept", u_if.req_accept, 2'b01);
    step(); u_if.req_valid = 2'b00;
    step(); #1;
    chk("mr_in_access", u_if.pen, 1'b1);
    RST_N = 1'b0;
    step(); RST_N = 1'b1; #1;
    chk("mr_psel", u_if.psel, 1'b0);
    chk("mr_pen", u_if.pen, 1'b0);
    chk("mr_pwrite", u_if.pwrite, 1'b0);
    chk("mr_paddr", u_if.paddr, 8'h00);
    chk("mr_pwdata", u_if.pwdata, 8'h00);
    chk("mr_rsp_valid", u_if.rsp_valid, 2'b00);
    chk("mr_rsp_rdata", u_if.rsp_rdata, 8'h00);
    chk("mr_rsp_err", u_if.rsp_err, 1'b0);
    chk("mr_accept_idle", u_if.req_accept, 2'b00);
    step(); #1;
    chk("mr_no_rsp1", u_if.rsp_valid, 2'b00);
    step(); #1;
    chk("mr_no_rsp2", u_if.rsp_valid, 2'b00);
    step(); req(2'b11, 2'b00, 16'h0303, 16'h0000); #1;
    chk("mr_req0_first", u_if.req_accept, 2'b01);
    step(); u_if.req_valid = 2'b00;
    step(); step(); step(); #1;
    chk("mr_rsp_after", u_if.rsp_valid, 2'b01);
    chk("mr_rdata_after", u_if.rsp_rdata, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
APB_RR_MASTER -- requirements
Module: apb_rr_master

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of consecutive ACCESS cycles with PREADY low before the transfer is aborted; the legal range is 1..255.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 REQ_VALID  input  2  per-requester transfer request; bit i belongs to requester i.
REQ-005 REQ_WRITE  input  2  per-requester direction; 1 is write, 0 is read.
REQ-006 REQ_ADDR  input  16  requester i address on bits [8i+7:8i].
REQ-007 REQ_WDATA  input  16  requester i write data on bits [8i+7:8i].
REQ-008 REQ_ACCEPT  output  2  one-cycle pulse when requester i's request is taken; the requester may change its inputs in the next cycle.
REQ-009 RSP_VALID  output  2  one-cycle completion pulse to requester i.
REQ-010 RSP_RDATA  output  8  read data; valid while RSP_VALID is nonzero.
REQ-011 RSP_ERR  output  1  error flag; valid while RSP_VALID is nonzero.
REQ-012 PSEL, PEN, PWRITE  output  1 each  APB select, enable and direction.
REQ-013 PADDR, PWDATA  output  8 each  APB address and write data.
REQ-014 PREADY, PSLVERR  input  1 each  APB ready and slave error.
REQ-015 PRDATA  input  8  APB read data.

Function
REQ-016 The FSM has three states: IDLE, SETUP and ACCESS.
REQ-017 IDLE behaviour:
- PSEL=0 and PEN=0.
- If REQ_VALID is nonzero, select a winner w, latch REQ_WRITE[w], REQ_ADDR[w] and REQ_WDATA[w], assert REQ_ACCEPT[w] combinationally in that same cycle, and go to SETUP.
- Otherwise stay in IDLE.
REQ-018 Arbitration:
- If exactly one REQ_VALID bit is set, that requester wins.
- If both are set, the winner is the requester that is not LAST.
- LAST is updated to w on every grant.
REQ-019 SETUP lasts exactly one cycle with PSEL=1 and PEN=0; the next state is ACCESS.
REQ-020 ACCESS drives PSEL=1 and PEN=1 and holds there while PREADY=0 and no timeout has occurred.
REQ-021 PADDR, PWDATA and PWRITE come from the latched registers and stay constant from SETUP through the final ACCESS cycle.
REQ-022 Completion is the ACCESS cycle with PREADY=1. On completion:
- capture PRDATA for reads, or 0 for writes;
- capture PSLVERR as the error;
- go to IDLE.
REQ-023 Wait timer:
- Counts ACCESS cycles with PREADY=0.
- Clears on entry to SETUP.
- When TIMEOUT such cycles have elapsed, abort: error=1, data=0, next state IDLE.
REQ-024 One cycle after completion or abort, RSP_VALID[w] pulses for exactly one cycle with RSP_RDATA and RSP_ERR; RSP_RDATA and RSP_ERR then hold until the next response.
REQ-025 A response pulse and a new grant in the same IDLE cycle are permitted and independent.
REQ-026 There is at most one transfer in flight. Request bits for the requester in service are ignored until the FSM returns to IDLE.
REQ-027 The minimum latency is 2 cycles from REQ_ACCEPT to the first ACCESS cycle. Against a slave that registers PREADY one cycle after it sees PEN, RSP_VALID arrives 4 cycles after REQ_ACCEPT.
REQ-028 REQ_VALID withdrawn before accept creates no obligation; IDLE re-evaluates the inputs every cycle.
REQ-029 PSLVERR and PRDATA are ignored outside completion cycles.

Reset
REQ-030 On a clock edge with RST_N=0:
- state=IDLE and LAST=1, so requester 0 wins first;
- the wait timer and latched fields are cleared;
- PSEL, PEN, PWRITE, PADDR, PWDATA, RSP_VALID, RSP_RDATA and RSP_ERR are all 0.
REQ-031 REQ_ACCEPT is 0 while RST_N=0.
REQ-032 Reset during SETUP or ACCESS aborts the transfer silently: no RSP_VALID is generated, and PSEL and PEN are low in the cycle after the reset edge.

Verification
REQ-033 Req0 writes addr 0x03 data 0xA5, then req1 reads addr 0x03 -> RSP_VALID[1]=1, RSP_RDATA=0xA5, RSP_ERR=0.
REQ-034 Against a one-cycle-ready slave, REQ_ACCEPT[0] at cycle T -> SETUP at T+1, ACCESS at T+2 and T+3, RSP_VALID[0] at T+4.
REQ-035 Both REQ_VALID held high after reset -> grants follow 0,1,0,1, and each requester's RSP_VALID precedes the next grant's SETUP.
REQ-036 PREADY tied to 0 with TIMEOUT=4 -> exactly 4 ACCESS cycles, then PSEL=0, RSP_ERR=1, RSP_RDATA=0x00.
REQ-037 PSLVERR=1 together with PREADY=1 on a read -> RSP_ERR=1 and RSP_RDATA equal to PRDATA.
REQ-038 RST_N=0 for one cycle during ACCESS -> next cycle all outputs are 0, no RSP_VALID is seen, and a later request from requester 0 is granted first.
